// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit counter width: $clog2(width), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference and borrow of a single bit position.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             di;
  logic             bo_next;

  // The single borrow cell, time-multiplexed across all bit positions.
  full_subtractor u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (br),
    .d  (di),
    .bo (bo_next)
  );

  // FSM, operand shift registers, borrow flop, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            d     <= '0;
            bout  <= 1'b0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Difference bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
          d   <= {di, d[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= bo_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bout  <= bo_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor with a start/busy/done handshake, computing D = A − B − Bin one bit per clock, LSB first. It is the inverse-operation counterpart to the combinational ripple-carry adder. Each clock it produces one difference bit and a rippled borrow, so the borrow chain is time-multiplexed through a single full-subtractor cell instead of replicated in space. It is used wherever area matters more than latency, and as a cross-check engine against the adder datapath.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- d  output  WIDTH  difference, valid while done=1 and held until next accepted start
- bout  output  1  borrow-out (1 = A < B + Bin unsigned), same validity as d
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load a/b into shift registers, bin into borrow flop, clear bit counter and d register; go to RUN.
  - start=0 → stay in IDLE.
- RUN, per cycle:
  - di = ai ^ bi ^ br
  - br' = (~ai & bi) | (~(ai ^ bi) & br)
  - di shifts into d from the MSB side; a and b shift right; counter increments.
  - When counter reaches WIDTH−1 → go to DONE.
- DONE: done=1 for exactly one cycle; bout = final br; go to IDLE unconditionally.
- start in RUN or DONE is ignored and not queued.
- a, b, bin are don't-care except on the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH: d = (a − b − bin) mod 2^WIDTH, bout = borrow of that subtraction.
- Reset, at any time including mid-RUN, applies immediately:
  - state=IDLE; d=0, bout=0, busy=0, done=0; counter, shift registers and borrow flop cleared.
  - The partial result is discarded.

## Timing
- Accepting edge k (IDLE, start=1): busy=1 after edge k.
- Edges k+1 … k+WIDTH each process one bit.
- After edge k+WIDTH: state DONE, busy=0, done=1, d/bout final.
- After edge k+WIDTH+1: IDLE, done=0, d/bout held.
- Start-to-done latency WIDTH cycles.
- Earliest next accept is at edge k+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- busy and done are never high simultaneously.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/header holds:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - width of the bit counter, $clog2(WIDTH)
- Sub-module full_subtractor: 1-bit combinational cell, ports (x, y, bi → d, bo), instantiated once in RUN datapath.
- Top holds the FSM, counter, shift registers and borrow flop.

## Test plan
- WIDTH=4, a=0000, b=0000, bin=0 → after 4 cycles: done pulse, d=0000, bout=0; busy high exactly 4 cycles.
- a=1111, b=0001, bin=0 → d=1110, bout=0.
- a=0001, b=0010, bin=0 → d=1111, bout=1 (underflow); then a=0000, b=0000, bin=1 → d=1111, bout=1.
- Start held high continuously with a=0101, b=0011 → results d=0010 every WIDTH+2 cycles; pulses during RUN/DONE not accepted.
- Assert rst_n=0 two cycles into RUN → busy/done/d/bout read 0 immediately; after release, no done until a new start; a subsequent a=1000, b=0001 gives d=0111, bout=0.
- WIDTH=8, a=8'h00, b=8'hFF, bin=1 → d=8'h00, bout=1, done 8 cycles after accept.
